// File: rtl/lcd_timing_pkg.sv
// lcd_timing_pkg
// Shared definitions for the RGB-LCD timing generator:
//   - default panel timing (800x480 class panel)
//   - FSM state type for the run/stop controller
//   - rgb565_to_888: RGB565 -> RGB888 expansion by MSB replication
//   - bar_rgb: colour table for the optional test pattern
//     (the pattern is only used when LCD_TEST_PATTERN_EN is defined)
package lcd_timing_pkg;

    localparam int unsigned DEF_H_ACTIVE = 800;
    localparam int unsigned DEF_H_FP     = 40;
    localparam int unsigned DEF_H_SYNC   = 128;
    localparam int unsigned DEF_H_BP     = 88;
    localparam int unsigned DEF_V_ACTIVE = 480;
    localparam int unsigned DEF_V_FP     = 13;
    localparam int unsigned DEF_V_SYNC   = 3;
    localparam int unsigned DEF_V_BP     = 29;
    localparam int unsigned DEF_CNT_W    = 12;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStopping
    } lcd_state_e;

    // Replicating the top bits makes full-scale 565 map to full-scale 888.
    function automatic logic [23:0] rgb565_to_888(input logic [15:0] d);
        return {d[15:11], d[15:13], d[10:5], d[10:9], d[4:0], d[4:2]};
    endfunction

    // Bit 0 = red, bit 1 = green, bit 2 = blue.
    function automatic logic [23:0] bar_rgb(input logic [2:0] idx);
        logic [23:0] c;
        case (idx)
            3'd0:    c = 24'h000000;
            3'd1:    c = 24'hFF0000;
            3'd2:    c = 24'h00FF00;
            3'd3:    c = 24'hFFFF00;
            3'd4:    c = 24'h0000FF;
            3'd5:    c = 24'hFF00FF;
            3'd6:    c = 24'h00FFFF;
            default: c = 24'hFFFFFF;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/lcd_hv_counter.sv
// lcd_hv_counter
// Horizontal/vertical position counters with region decode.
// Line order is SYNC, BP, ACTIVE, FP; frame order likewise in lines.
// Ports:
//   clk_i        pixel clock
//   rst_i        synchronous reset, active-high
//   run_i        advance counters; when low both counters are held at 0
//   h_sync_o     h in sync region      v_sync_o  v in sync region
//   h_act_o      h in active region    v_act_o   v in active region
//   first_o      h == 0 and v == 0
//   frame_end_o  last pixel of the frame (h and v both at their last value)
//   x_o / y_o    offsets from the start of the active region (valid when active)
module lcd_hv_counter #(
    parameter int unsigned H_ACTIVE = 800,
    parameter int unsigned H_FP     = 40,
    parameter int unsigned H_SYNC   = 128,
    parameter int unsigned H_BP     = 88,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 13,
    parameter int unsigned V_SYNC   = 3,
    parameter int unsigned V_BP     = 29,
    parameter int unsigned CNT_W    = 12
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             run_i,
    output logic             h_sync_o,
    output logic             v_sync_o,
    output logic             h_act_o,
    output logic             v_act_o,
    output logic             first_o,
    output logic             frame_end_o,
    output logic [CNT_W-1:0] x_o,
    output logic [CNT_W-1:0] y_o
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int unsigned V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;

    localparam logic [CNT_W-1:0] HSyncEnd = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] HActBeg  = CNT_W'(H_SYNC + H_BP);
    localparam logic [CNT_W-1:0] HActEnd  = CNT_W'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [CNT_W-1:0] HLast    = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] VSyncEnd = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] VActBeg  = CNT_W'(V_SYNC + V_BP);
    localparam logic [CNT_W-1:0] VActEnd  = CNT_W'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [CNT_W-1:0] VLast    = CNT_W'(V_TOTAL - 1);

    logic [CNT_W-1:0] h_q, h_d, v_q, v_d;
    logic             h_wrap;

    assign h_wrap = (h_q == HLast);

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (!run_i) begin
            h_d = '0;
            v_d = '0;
        end else if (h_wrap) begin
            h_d = '0;
            v_d = (v_q == VLast) ? '0 : v_q + 1'b1;
        end else begin
            h_d = h_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_q <= '0;
            v_q <= '0;
        end else begin
            h_q <= h_d;
            v_q <= v_d;
        end
    end

    assign h_sync_o    = (h_q < HSyncEnd);
    assign v_sync_o    = (v_q < VSyncEnd);
    assign h_act_o     = (h_q >= HActBeg) && (h_q < HActEnd);
    assign v_act_o     = (v_q >= VActBeg) && (v_q < VActEnd);
    assign first_o     = (h_q == '0) && (v_q == '0);
    assign frame_end_o = h_wrap && (v_q == VLast);
    assign x_o         = h_q - HActBeg;
    assign y_o         = v_q - VActBeg;

endmodule

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// RGB-LCD timing generator and pixel pump. Generates DE/HSYNC/VSYNC, reads RGB565
// pixels from the line FIFO, expands them to RGB888 and flags FIFO underflow.
// Ports:
//   PixelClk       pixel clock (all logic on rising edge)
//   RST            synchronous reset, active-high
//   Enable         run request; start/stop happen on frame boundaries
//   FIFO_RE        FIFO read strobe (combinational); data valid the next cycle
//   FIFO_Empty     FIFO empty flag
//   FIFO_Data      RGB565 pixel {R5,G6,B5}
//   LCD_DE         data enable, active-high
//   LCD_HSYNC      horizontal sync, active level HS_POL
//   LCD_VSYNC      vertical sync, active level VS_POL
//   VGA_R/G/B      RGB888 pixel colour
//   FrameStart     1-cycle pulse with the first HSYNC cycle of a frame
//   PixelX/PixelY  active-pixel coordinates, aligned with LCD_DE
//   Underflow      sticky: an active pixel found the FIFO empty
//   UnderflowClr   clears Underflow (a simultaneous new underflow wins)
//   PatternSel     only with LCD_TEST_PATTERN_EN: show 8 colour bars instead of FIFO data
// Macro: LCD_TEST_PATTERN_EN adds the PatternSel input and the colour-bar generator.
// Pixel read in cycle t reaches the pins at t+2; all timing outputs share that delay.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE  = DEF_H_ACTIVE,
    parameter int unsigned H_FP      = DEF_H_FP,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BP      = DEF_H_BP,
    parameter int unsigned V_ACTIVE  = DEF_V_ACTIVE,
    parameter int unsigned V_FP      = DEF_V_FP,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BP      = DEF_V_BP,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter logic [23:0] UFLOW_RGB = 24'hFF0000,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic             PixelClk,
    input  logic             RST,
    input  logic             Enable,
    output logic             FIFO_RE,
    input  logic             FIFO_Empty,
    input  logic [15:0]      FIFO_Data,
    output logic             LCD_DE,
    output logic             LCD_HSYNC,
    output logic             LCD_VSYNC,
    output logic [7:0]       VGA_R,
    output logic [7:0]       VGA_G,
    output logic [7:0]       VGA_B,
    output logic             FrameStart,
    output logic [CNT_W-1:0] PixelX,
    output logic [CNT_W-1:0] PixelY,
    output logic             Underflow,
    input  logic             UnderflowClr
`ifdef LCD_TEST_PATTERN_EN
    ,
    input  logic             PatternSel
`endif
);

    lcd_state_e       state_q;
    logic             running, active, pattern, uflow;
    logic             h_sync, v_sync, h_act, v_act, first, frame_end;
    logic [CNT_W-1:0] act_x, act_y;

    assign running = (state_q != StIdle);

    lcd_hv_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W   (CNT_W)
    ) u_hv (
        .clk_i      (PixelClk),
        .rst_i      (RST),
        .run_i      (running),
        .h_sync_o   (h_sync),
        .v_sync_o   (v_sync),
        .h_act_o    (h_act),
        .v_act_o    (v_act),
        .first_o    (first),
        .frame_end_o(frame_end),
        .x_o        (act_x),
        .y_o        (act_y)
    );

`ifdef LCD_TEST_PATTERN_EN
    assign pattern = PatternSel;
`else
    assign pattern = 1'b0;
`endif

    assign active  = running & h_act & v_act;
    assign FIFO_RE = active & ~FIFO_Empty & ~pattern;
    assign uflow   = active & FIFO_Empty & ~pattern;

    // Stopping only takes effect at the end of the frame; Enable returning cancels it.
    always_ff @(posedge PixelClk) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            unique case (state_q)
                StIdle:     if (Enable) state_q <= StRun;
                StRun:      if (!Enable) state_q <= StStopping;
                StStopping: begin
                    if (Enable)         state_q <= StRun;
                    else if (frame_end) state_q <= StIdle;
                end
                default:    state_q <= StIdle;
            endcase
        end
    end

    // Stage 1: timing aligned with the FIFO data cycle.
    logic             s1_de_q, s1_hs_q, s1_vs_q, s1_fs_q, s1_uflow_q, s1_pat_q;
    logic [CNT_W-1:0] s1_x_q, s1_y_q;

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            s1_de_q    <= 1'b0;
            s1_hs_q    <= 1'b0;
            s1_vs_q    <= 1'b0;
            s1_fs_q    <= 1'b0;
            s1_uflow_q <= 1'b0;
            s1_pat_q   <= 1'b0;
            s1_x_q     <= '0;
            s1_y_q     <= '0;
        end else begin
            s1_de_q    <= active;
            s1_hs_q    <= running & h_sync;
            s1_vs_q    <= running & v_sync;
            s1_fs_q    <= running & first;
            s1_uflow_q <= uflow;
            s1_pat_q   <= active & pattern;
            s1_x_q     <= active ? act_x : '0;
            s1_y_q     <= active ? act_y : '0;
        end
    end

    // Stage 2: panel pins.
    logic             de_q, hs_q, vs_q, fs_q, uflow_q;
    logic [23:0]      rgb_q, rgb_d;
    logic [CNT_W-1:0] x_q, y_q;
    logic [2:0]       bar_idx;

    assign bar_idx = 3'((32'(s1_x_q) << 3) / H_ACTIVE);

    always_comb begin
        rgb_d = '0;
        if (s1_de_q) begin
            if (s1_pat_q)        rgb_d = bar_rgb(bar_idx);
            else if (s1_uflow_q) rgb_d = UFLOW_RGB;
            else                 rgb_d = rgb565_to_888(FIFO_Data);
        end
    end

    always_ff @(posedge PixelClk) begin
        if (RST) begin
            de_q  <= 1'b0;
            hs_q  <= ~HS_POL;
            vs_q  <= ~VS_POL;
            fs_q  <= 1'b0;
            rgb_q <= '0;
            x_q   <= '0;
            y_q   <= '0;
        end else begin
            de_q  <= s1_de_q;
            hs_q  <= s1_hs_q ? HS_POL : ~HS_POL;
            vs_q  <= s1_vs_q ? VS_POL : ~VS_POL;
            fs_q  <= s1_fs_q;
            rgb_q <= rgb_d;
            x_q   <= s1_x_q;
            y_q   <= s1_y_q;
        end
    end

    // Set has priority over clear so a same-cycle underflow is never lost.
    always_ff @(posedge PixelClk) begin
        if (RST)               uflow_q <= 1'b0;
        else if (uflow)        uflow_q <= 1'b1;
        else if (UnderflowClr) uflow_q <= 1'b0;
    end

    assign LCD_DE     = de_q;
    assign LCD_HSYNC  = hs_q;
    assign LCD_VSYNC  = vs_q;
    assign FrameStart = fs_q;
    assign VGA_R      = rgb_q[23:16];
    assign VGA_G      = rgb_q[15:8];
    assign VGA_B      = rgb_q[7:0];
    assign PixelX     = x_q;
    assign PixelY     = y_q;
    assign Underflow  = uflow_q;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen with a tiny panel: H total 8 (sync 0-1, bp 2, active 3-6,
// fp 7), V total 5 (sync 0, bp 1, active 2-3, fp 4), frame = 40 cycles.
// Index n = loop cycle; RUN with h=v=0 starts at n=0, counter cycle k reaches pins at n=k+2.
module tb_lcd_timing_gen;

    logic        clk = 1'b0;
    logic        rst, en, empty, clr;
    logic [15:0] data;
    logic        re, de, hs, vs, fs, uf;
    logic [7:0]  r, g, b;
    logic [11:0] px, py;
`ifdef LCD_TEST_PATTERN_EN
    logic        psel;
`endif

    always #5 clk = ~clk;

    lcd_timing_gen #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .UFLOW_RGB(24'hFF0000), .CNT_W(12)
    ) dut (
        .PixelClk    (clk),
        .RST         (rst),
        .Enable      (en),
        .FIFO_RE     (re),
        .FIFO_Empty  (empty),
        .FIFO_Data   (data),
        .LCD_DE      (de),
        .LCD_HSYNC   (hs),
        .LCD_VSYNC   (vs),
        .VGA_R       (r),
        .VGA_G       (g),
        .VGA_B       (b),
        .FrameStart  (fs),
        .PixelX      (px),
        .PixelY      (py),
        .Underflow   (uf),
        .UnderflowClr(clr)
`ifdef LCD_TEST_PATTERN_EN
        ,
        .PatternSel  (psel)
`endif
    );

    localparam int N = 300;

    int          checks = 0;
    int          failures = 0;
    logic        re_l[N], de_l[N], hs_l[N], vs_l[N], fs_l[N], uf_l[N];
    logic [23:0] rgb_l[N];
    logic [11:0] px_l[N], py_l[N];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int count_re(input int lo, input int hi);
        int c = 0;
        for (int i = lo; i <= hi; i++) c += int'(re_l[i]);
        return c;
    endfunction

    initial begin
        int c;
        rst = 1'b1; en = 1'b0; empty = 1'b0; clr = 1'b0; data = 16'h0000;
`ifdef LCD_TEST_PATTERN_EN
        psel = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_re", re, 0);
        chk("rst_de", de, 0);
        chk("rst_hs", hs, 1);
        chk("rst_vs", vs, 1);
        chk("rst_rgb", {r, g, b}, 0);
        chk("rst_fs", fs, 0);
        chk("rst_uf", uf, 0);
        en = 1'b1;

        for (int n = 0; n < N; n++) begin
            @(posedge clk);
            #1;
            rst   = (n == 192);
            en    = !((n >= 90 && n <= 129) || (n >= 140 && n <= 149));
            empty = (n == 68 || n == 75 || n == 100 || n == 191 || n == 254);
            clr   = (n == 72 || n == 100 || n == 104);
            data  = (n < 40) ? 16'hF800 : ((n == 60) ? 16'h0841 : 16'h07E0);
`ifdef LCD_TEST_PATTERN_EN
            psel  = (n >= 234);
`endif
            #1;
            re_l[n] = re; de_l[n] = de; hs_l[n] = hs; vs_l[n] = vs;
            fs_l[n] = fs; uf_l[n] = uf; rgb_l[n] = {r, g, b};
            px_l[n] = px; py_l[n] = py;
        end

        // Frame 1: basic timing
        chk("f1_re_count", count_re(0, 39), 8);
        chk("f1_re_18", re_l[18], 0);
        chk("f1_re_19", re_l[19], 1);
        chk("hs_2", hs_l[2], 0);
        chk("hs_3", hs_l[3], 0);
        chk("hs_4", hs_l[4], 1);
        chk("hs_10", hs_l[10], 0);
        c = 0;
        for (int i = 2; i <= 41; i++) c += int'(!hs_l[i]);
        chk("hs_low_count", c, 10);
        chk("vs_9", vs_l[9], 0);
        chk("vs_10", vs_l[10], 1);
        chk("vs_42", vs_l[42], 0);
        chk("fs_2", fs_l[2], 1);
        chk("fs_3", fs_l[3], 0);
        chk("fs_42", fs_l[42], 1);
        c = 0;
        for (int i = 2; i <= 41; i++) c += int'(de_l[i]);
        chk("de_count", c, 8);
        chk("de_20", de_l[20], 0);
        chk("de_21", de_l[21], 1);
        chk("de_25", de_l[25], 0);
        chk("rgb_21", rgb_l[21], 24'hFF0000);
        chk("px_21", px_l[21], 0);
        chk("px_24", px_l[24], 3);
        chk("py_29", py_l[29], 1);

        // Expansion and read-to-pin latency
        chk("re_59", re_l[59], 1);
        chk("rgb_61", rgb_l[61], 24'h080808);
        chk("rgb_62", rgb_l[62], 24'h00FF00);

        // Underflow
        chk("re_67", re_l[67], 1);
        chk("re_68_empty", re_l[68], 0);
        chk("rgb_69", rgb_l[69], 24'h00FF00);
        chk("rgb_70_uflow", rgb_l[70], 24'hFF0000);
        chk("de_70", de_l[70], 1);
        chk("uf_68", uf_l[68], 0);
        chk("uf_69", uf_l[69], 1);
        chk("uf_72_sticky", uf_l[72], 1);
        chk("uf_73_clr", uf_l[73], 0);
        chk("uf_76_inactive", uf_l[76], 0);
        chk("uf_100", uf_l[100], 0);
        chk("uf_101_setwins", uf_l[101], 1);
        chk("uf_105_clr", uf_l[105], 0);

        // Stop at frame end, restart, cancelled stop
        chk("de_101_stopping", de_l[101], 1);
        chk("re_107_stopping", re_l[107], 1);
        chk("idle_re_count", count_re(120, 130), 0);
        chk("idle_fs_122", fs_l[122], 0);
        chk("idle_hs_122", hs_l[122], 1);
        chk("idle_de_125", de_l[125], 0);
        chk("idle_rgb_125", rgb_l[125], 0);
        chk("restart_fs_133", fs_l[133], 1);
        chk("re_150", re_l[150], 1);
        chk("nogap_fs_173", fs_l[173], 1);

        // Reset mid-active-line
        chk("pre_rst_uf", uf_l[192], 1);
        chk("pre_rst_de", de_l[192], 1);
        chk("rst_de_193", de_l[193], 0);
        chk("rst_rgb_193", rgb_l[193], 0);
        chk("rst_hs_193", hs_l[193], 1);
        chk("rst_vs_193", vs_l[193], 1);
        chk("rst_uf_193", uf_l[193], 0);
        chk("rst_fs_193", fs_l[193], 0);
        chk("rst_re_193", re_l[193], 0);
        chk("rst_fs_195", fs_l[195], 0);
        chk("rst_fs_196", fs_l[196], 1);
        chk("rst_re_212", re_l[212], 0);
        chk("rst_re_213", re_l[213], 1);

`ifdef LCD_TEST_PATTERN_EN
        chk("pat_re_count", count_re(234, 273), 0);
        chk("pat_de_256", de_l[256], 1);
        chk("pat_rgb_255", rgb_l[255], 24'h000000);
        chk("pat_rgb_256", rgb_l[256], 24'h00FF00);
        chk("pat_rgb_257", rgb_l[257], 24'h0000FF);
        chk("pat_rgb_258", rgb_l[258], 24'h00FFFF);
        chk("pat_uf_255", uf_l[255], 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
